pipe_mac_sink: RTL and testbench
================================

PIPE_MAC_SINK -- requirements
Module: pipe_mac_sink

Interface
REQ-001 Parameter: ACC_W, default 12, accumulator and result width in bits (legal range 8..16).
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  begin a burst; sampled only in IDLE.
REQ-005 len  input  4  burst length, captured on start; 0 means 16.
REQ-006 w  input  4  weight, captured on start, held for the whole burst.
REQ-007 stall_in  input  1  local backpressure; forces in_ready low.
REQ-008 in_valid  input  1  upstream element valid.
REQ-009 in_data  input  4  upstream element, unsigned.
REQ-010 in_ready  output  1  sink can accept an element this cycle.
REQ-011 busy  output  1  high in RUN, DRAIN or RESULT.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  result consumer ready.
REQ-014 acc_out  output  ACC_W  accumulated result.

Function
REQ-015 The FSM SHALL have states IDLE, RUN, DRAIN and RESULT.
REQ-016 IDLE->RUN SHALL occur on start=1: capture len (0 maps to 16), capture w, clear acc, set remaining=len.
REQ-017 in_ready SHALL equal (state==RUN) & (remaining!=0) & !stall_in; it SHALL be 0 in IDLE, DRAIN and RESULT.
REQ-018 Accept (in_valid & in_ready) at edge k SHALL register prod = in_data*w (8-bit, exact) and decrement remaining.
REQ-019 prod valid at edge k+1 SHALL be added to acc, modulo 2^ACC_W (zero-extended product).
REQ-020 RUN->DRAIN SHALL occur at the edge accepting the last element; DRAIN->RESULT SHALL occur one edge later, once the final product is absorbed.
REQ-021 out_valid SHALL be 1 exactly in RESULT, first asserted 2 cycles after the last accept edge; acc_out SHALL equal acc and remain stable while out_valid=1 and out_ready=0.
REQ-022 RESULT->IDLE SHALL occur on out_ready=1; start in the same cycle SHALL be ignored.
REQ-023 start while not in IDLE SHALL be ignored and SHALL NOT alter len, w or acc.
REQ-024 in_valid without in_ready SHALL have no effect; in_data SHALL be ignored when not accepted.
REQ-025 Back-to-back accepts SHALL be supported: one element per cycle, with no bubble inserted by the sink.
REQ-026 stall_in asserted mid-burst SHALL pause acceptance only; a product already registered SHALL still be accumulated.

Reset
REQ-027 On rst=1: state=IDLE, acc=0, prod valid=0, remaining=0, in_ready=0, busy=0, out_valid=0, acc_out=0.
REQ-028 rst asserted mid-burst SHALL abort the burst with no result emitted; rst SHALL take priority over all other inputs.

Configuration
REQ-029 Macro MAC_OVF_EN: when defined, add output ovf (1 bit), a sticky flag set when any accumulate carries out of ACC_W.
REQ-030 With MAC_OVF_EN: ovf SHALL be cleared on rst and on an accepted start, and SHALL be valid alongside out_valid.
REQ-031 Without MAC_OVF_EN: the ovf port and logic SHALL be absent; wrap-around SHALL be silent.

Verification
REQ-032 ACC_W=12: start with len=4, w=3, data 1,2,3,4 back-to-back -> out_valid 2 cycles after 4th accept, acc_out=30.
REQ-033 len=0, w=15, 16 elements of 15 -> exactly 16 accepts, then in_ready=0, acc_out=3600.
REQ-034 stall_in=1 for 3 cycles mid-burst of len=2, w=2, data 5,7 -> in_ready=0 during stall, acc_out=24.
REQ-035 out_ready=0 for 5 cycles in RESULT -> acc_out and out_valid held; start pulses ignored; IDLE after out_ready=1.
REQ-036 ACC_W=8 with MAC_OVF_EN: w=15, len=2, data 15,15 -> acc_out=194, ovf=1; next start clears ovf.
REQ-037 rst after 2 of 4 elements accepted -> all outputs reset values; new burst with len=1, w=1, data 9 -> acc_out=9.

Source files
------------

// File: rtl/pipe_mac_sink.sv
// pipe_mac_sink: burst multiply-accumulate sink.
// A start in IDLE captures a burst length (0 = 16) and a weight, then the sink
// accepts that many 4-bit elements, multiplies each by the weight into a
// registered product and adds that product into the accumulator one cycle
// later. The sum is presented until the consumer takes it.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start, len, w      burst request, length (0 = 16), weight
//   stall_in           local backpressure, forces in_ready low
//   in_valid, in_data  upstream element handshake and payload
//   in_ready           element accepted this cycle when in_valid is also high
//   busy               burst in progress (RUN, DRAIN or RESULT)
//   out_valid          result available (RESULT state)
//   out_ready          result consumer ready
//   acc_out            accumulated result, ACC_W bits, wraps modulo 2^ACC_W
//   ovf                sticky carry-out flag, present only with MAC_OVF_EN
//
// Optional feature: define MAC_OVF_EN to add the ovf output.
module pipe_mac_sink #(
  parameter int unsigned ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       len,
  input  logic [3:0]       w,
  input  logic             stall_in,
  input  logic             in_valid,
  input  logic [3:0]       in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out
`ifdef MAC_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned SUM_W  = ACC_W + 1;
  localparam int unsigned PROD_W = 8;
  localparam int unsigned REM_W  = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    RESULT = 2'd3
  } state_t;

  state_t              state;
  logic [REM_W-1:0]    remaining;
  logic [3:0]          w_q;
  logic [PROD_W-1:0]   prod;
  logic                prod_vld;
  logic [ACC_W-1:0]    acc;
  logic                accept;
  logic [SUM_W-1:0]    sum;

  // Acceptance depends on stall_in in the same cycle, so in_ready is combinational.
  assign in_ready  = (state == RUN) && (remaining != REM_W'(0)) && !stall_in;
  assign accept    = in_valid && in_ready;
  assign busy      = (state != IDLE);
  assign out_valid = (state == RESULT);
  assign acc_out   = acc;

  // Extra top bit of the sum is the carry out of the accumulator.
  assign sum = {1'b0, acc} + SUM_W'(prod);

  // Burst control, product stage and accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      w_q       <= '0;
      prod      <= '0;
      prod_vld  <= 1'b0;
      acc       <= '0;
`ifdef MAC_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      prod_vld <= accept;
      if (accept) begin
        prod <= PROD_W'(in_data) * PROD_W'(w_q);
      end

      // A registered product is absorbed regardless of stall or state.
      if (prod_vld) begin
        acc <= sum[ACC_W-1:0];
`ifdef MAC_OVF_EN
        if (sum[ACC_W]) begin
          ovf <= 1'b1;
        end
`endif
      end

      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            remaining <= (len == 4'd0) ? REM_W'(16) : REM_W'(len);
            w_q       <= w;
            acc       <= '0;
`ifdef MAC_OVF_EN
            ovf       <= 1'b0;
`endif
          end
        end
        RUN: begin
          if (accept) begin
            remaining <= remaining - REM_W'(1);
            if (remaining == REM_W'(1)) begin
              state <= DRAIN;
            end
          end
        end
        // Final product is added at this edge.
        DRAIN: begin
          state <= RESULT;
        end
        RESULT: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_mac_sink.sv
// Directed bench for pipe_mac_sink: a 12-bit and an 8-bit accumulator instance
// share all stimulus; a table of bursts plus hand-written reset sequences.
module tb_pipe_mac_sink;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  len;
  logic [3:0]  w;
  logic        stall_in;
  logic        in_valid;
  logic [3:0]  in_data;
  logic        out_ready;

  logic        rdy12, busy12, ov12;
  logic [11:0] acc12;
  logic        rdy8, busy8, ov8;
  logic [7:0]  acc8;
`ifdef MAC_OVF_EN
  logic        ovf12, ovf8;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pipe_mac_sink #(.ACC_W(12)) u_dut12 (
    .clk(clk), .rst(rst), .start(start), .len(len), .w(w),
    .stall_in(stall_in), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy12), .busy(busy12), .out_valid(ov12),
    .out_ready(out_ready), .acc_out(acc12)
`ifdef MAC_OVF_EN
    , .ovf(ovf12)
`endif
  );

  pipe_mac_sink #(.ACC_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start), .len(len), .w(w),
    .stall_in(stall_in), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy8), .busy(busy8), .out_valid(ov8),
    .out_ready(out_ready), .acc_out(acc8)
`ifdef MAC_OVF_EN
    , .ovf(ovf8)
`endif
  );

  typedef struct {
    logic [3:0]  len;
    logic [3:0]  w;
    logic [63:0] data;     // element i in bits [4i+3:4i]
    int          stall_at; // element index preceded by a stall, -1 for none
    int          stall_n;
    int          hold;     // cycles of out_ready=0 in RESULT
    int          exp_sum;  // exact (unwrapped) hand-computed sum
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic run_burst(input vec_t v);
    int n;
    logic [11:0] exp12;
    logic [7:0]  exp8;
    n     = (v.len == 4'd0) ? 16 : int'(v.len);
    exp12 = 12'(v.exp_sum);
    exp8  = 8'(v.exp_sum);

    @(negedge clk);
    start = 1'b1; len = v.len; w = v.w;
    @(negedge clk);
    start = 1'b0; len = 4'd1; w = 4'd0;
    chk("busy_after_start", 32'(busy12), 1);
`ifdef MAC_OVF_EN
    chk("ovf8_cleared_on_start", 32'(ovf8), 0);
`endif

    for (int i = 0; i < n; i++) begin
      if (i == v.stall_at) begin
        for (int s = 0; s < v.stall_n; s++) begin
          stall_in = 1'b1; in_valid = 1'b1; in_data = 4'hE;
          #1;
          chk("in_ready_stalled", 32'(rdy12), 0);
          @(negedge clk);
        end
        stall_in = 1'b0;
      end
      in_valid = 1'b1;
      in_data  = v.data[4*i +: 4];
      #1;
      chk($sformatf("in_ready_elem%0d", i), 32'(rdy12), 1);
      @(negedge clk);
    end

    // Last accept edge passed: DRAIN, junk data must not be accepted.
    in_data = 4'hF;
    #1;
    chk("in_ready_after_last", 32'(rdy12), 0);
    chk("out_valid_in_drain", 32'(ov12), 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("out_valid_result", 32'(ov12), 1);
    chk("acc12", 32'(acc12), 32'(exp12));
    chk("acc8", 32'(acc8), 32'(exp8));
    chk("out_valid8", 32'(ov8), 1);
`ifdef MAC_OVF_EN
    chk("ovf12", 32'(ovf12), (v.exp_sum >= 4096) ? 1 : 0);
    chk("ovf8", 32'(ovf8), (v.exp_sum >= 256) ? 1 : 0);
`endif

    for (int h = 0; h < v.hold; h++) begin
      start = h[0]; len = 4'd3; w = 4'd9;
      @(negedge clk);
      chk("held_out_valid", 32'(ov12), 1);
      chk("held_acc12", 32'(acc12), 32'(exp12));
    end

    // Consume result; simultaneous start must be ignored.
    out_ready = 1'b1; start = 1'b1; len = 4'd2; w = 4'd7;
    @(negedge clk);
    out_ready = 1'b0; start = 1'b0;
    chk("idle_out_valid", 32'(ov12), 0);
    chk("idle_busy", 32'(busy12), 0);
    chk("idle_acc_unchanged", 32'(acc12), 32'(exp12));
  endtask

  vec_t vecs [6];
  vec_t tail;

  initial begin
    vecs[0] = '{4'd4, 4'd3,  64'h4321,              -1, 0, 0, 30};
    vecs[1] = '{4'd0, 4'd15, 64'hFFFF_FFFF_FFFF_FFFF, -1, 0, 0, 3600};
    vecs[2] = '{4'd2, 4'd2,  64'h75,                1,  3, 0, 24};
    vecs[3] = '{4'd3, 4'd5,  64'h0A1,               -1, 0, 5, 55};
    vecs[4] = '{4'd2, 4'd15, 64'hFF,                -1, 0, 0, 450};
    vecs[5] = '{4'd1, 4'd0,  64'h9,                 -1, 0, 0, 0};
    tail    = '{4'd1, 4'd1,  64'h9,                 -1, 0, 0, 9};

    rst = 1'b1; start = 1'b0; len = 4'd0; w = 4'd0; stall_in = 1'b0;
    in_valid = 1'b1; in_data = 4'd5; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(rdy12), 0);
    chk("rst_busy", 32'(busy12), 0);
    chk("rst_out_valid", 32'(ov12), 0);
    chk("rst_acc", 32'(acc12), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 32'(rdy12), 0);
    in_valid = 1'b0;

    for (int k = 0; k < 6; k++) run_burst(vecs[k]);

    // Abort after two accepts of a four-element burst.
    @(negedge clk);
    start = 1'b1; len = 4'd4; w = 4'd1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; in_data = 4'd3;
    repeat (2) @(negedge clk);
    chk("mid_busy", 32'(busy12), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy12), 0);
    chk("abort_out_valid", 32'(ov12), 0);
    chk("abort_acc", 32'(acc12), 0);
    chk("abort_in_ready", 32'(rdy12), 0);
    rst = 1'b0; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_result", 32'(ov12), 0);
    run_burst(tail);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
